// File: rtl/slave_3_pkg.sv
// Shared types and helpers for the slave_3 consumer: default data width, a beat
// typedef and the FIFO pointer-width helper.
package slave_3_pkg;

  localparam int unsigned DataW = 32;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic             valid;
  } beat_t;

  // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/slave_3_if.sv
// Upstream (data/valid/ready) and downstream (out_*) valid/ready links of slave_3.
interface slave_3_if import slave_3_pkg::*; #(
   parameter int unsigned DATA_W = DataW
) ();

   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  data, valid, out_ready,
      output ready, out_data, out_valid
   );

   modport master (
      output data, valid, out_ready,
      input  ready, out_data, out_valid
   );

endinterface

// File: rtl/slave_3_sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered ready; head data is read
// straight from storage so a write into an empty FIFO shows up one clock later.
module slave_3_sync_fifo_fwft import slave_3_pkg::*; #(
   parameter int unsigned DATA_W = DataW,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   output logic              push_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rvalid_o,
   input  logic              rready_i
);

   localparam int unsigned PtrW = ptr_w(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              ready_q, ready_d;
   logic              push, pop;

   assign push     = wvalid_i & ready_q;
   assign pop      = rvalid_o & rready_i;
   assign rvalid_o = (count_q != '0);
   assign rdata_o  = mem_q[rd_ptr_q];
   assign wready_o = ready_q;
   assign push_o   = push;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q + CntW'(push) - CntW'(pop);
      // Registered from the next count, so neither valid nor out_ready reaches ready.
      ready_d  = (count_d < CntW'(DEPTH));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/slave_3.sv
// Consumer for the counting master: buffers beats in a FWFT FIFO and checks the
// accepted stream against an incrementing sequence.
module slave_3 import slave_3_pkg::*; #(
   parameter int unsigned DATA_W = DataW,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ERR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   slave_3_if.slave          link,
   output logic [31:0]       beat_cnt_o,
   output logic [ERR_W-1:0]  err_cnt_o,
   output logic [DATA_W-1:0] last_data_o
);

   logic              push;
   logic [31:0]       beat_cnt_q, beat_cnt_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [DATA_W-1:0] last_data_q, last_data_d;
   logic [DATA_W-1:0] expected_q, expected_d;
   logic              seq_armed_q, seq_armed_d;

   slave_3_sync_fifo_fwft #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i    (clk),
      .rst_i    (rst),
      .wdata_i  (link.data),
      .wvalid_i (link.valid),
      .wready_o (link.ready),
      .push_o   (push),
      .rdata_o  (link.out_data),
      .rvalid_o (link.out_valid),
      .rready_i (link.out_ready)
   );

   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      err_cnt_d   = err_cnt_q;
      last_data_d = last_data_q;
      expected_d  = expected_q;
      seq_armed_d = seq_armed_q;
      if (push) begin
         beat_cnt_d  = beat_cnt_q + 32'd1;
         last_data_d = link.data;
         if (!seq_armed_q) begin
            seq_armed_d = 1'b1;
            expected_d  = link.data + DATA_W'(1);
         end else if (link.data != expected_q) begin
            if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            // Resync onto the observed value so one gap costs one error.
            expected_d = link.data + DATA_W'(1);
         end else begin
            expected_d = expected_q + DATA_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         err_cnt_q   <= '0;
         last_data_q <= '0;
         expected_q  <= '0;
         seq_armed_q <= 1'b0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         err_cnt_q   <= err_cnt_d;
         last_data_q <= last_data_d;
         expected_q  <= expected_d;
         seq_armed_q <= seq_armed_d;
      end
   end

   assign beat_cnt_o  = beat_cnt_q;
   assign err_cnt_o   = err_cnt_q;
   assign last_data_o = last_data_q;

endmodule

// File: tb/tb_slave_3.sv
// Bench for slave_3: directed and random streams checked against a queue-based
// model of the FIFO and a "next beat must be previous+1" sequence model.
module tb_slave_3;

   localparam int unsigned Depth = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] beat_cnt;
   logic [15:0] err_cnt;
   logic [31:0] last_data;

   slave_3_if #(.DATA_W(32)) link ();

   slave_3 #(
      .DATA_W (32),
      .DEPTH  (Depth),
      .ERR_W  (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .link        (link),
      .beat_cnt_o  (beat_cnt),
      .err_cnt_o   (err_cnt),
      .last_data_o (last_data)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [31:0] m_q[$];
   bit          m_ready;
   bit          m_armed;
   logic [31:0] m_exp;
   logic [31:0] m_beats;
   int unsigned m_err;
   logic [31:0] m_last;
   logic [31:0] mctr;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check_eq("ready", 64'(link.ready), 64'(m_ready));
      check_eq("out_valid", 64'(link.out_valid), 64'(m_q.size() > 0));
      if (m_q.size() > 0) check_eq("out_data", 64'(link.out_data), 64'(m_q[0]));
      check_eq("beat_cnt", 64'(beat_cnt), 64'(m_beats));
      check_eq("err_cnt", 64'(err_cnt), 64'(m_err));
      check_eq("last_data", 64'(last_data), 64'(m_last));
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ready = 1'b0;
      m_armed = 1'b0;
      m_exp   = '0;
      m_beats = '0;
      m_err   = 0;
      m_last  = '0;
   endtask

   // One clock: drive inputs, advance past the edge, update the model, compare.
   task automatic step(input bit v, input logic [31:0] d, input bit ordy);
      bit push, pop;
      link.valid     = v;
      link.data      = d;
      link.out_ready = ordy;
      push = v && m_ready;
      pop  = (m_q.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (pop) m_q.delete(0);
      if (push) begin
         m_q.push_back(d);
         m_beats = m_beats + 32'd1;
         m_last  = d;
         if (m_armed && d != m_exp && m_err < 32'hFFFF) m_err++;
         m_armed = 1'b1;
         m_exp   = d + 32'd1;
      end
      m_ready = (m_q.size() < Depth);
      check_all();
   endtask

   task automatic stream(input int n, input bit ordy);
      for (int i = 0; i < n; i++) begin
         step(1'b1, mctr, ordy);
         mctr = mctr + 32'd1;
      end
   endtask

   // Asynchronous pulse away from the clock edge; effects must be immediate.
   task automatic pulse_reset();
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      link.valid     = 1'b0;
      link.data      = '0;
      link.out_ready = 1'b0;
      model_reset();
      #2;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Continuous 1..20 with the sink always ready.
      step(1'b0, 32'd0, 1'b1);
      check_eq("ready_after_release", 64'(link.ready), 64'd1);
      mctr = 32'd1;
      stream(20, 1'b1);
      check_eq("t1_beats", 64'(beat_cnt), 64'd20);
      check_eq("t1_err", 64'(err_cnt), 64'd0);
      check_eq("t1_last", 64'(last_data), 64'd20);
      step(1'b0, 32'd0, 1'b1);

      // Backpressure: master keeps counting while the FIFO is full.
      pulse_reset();
      step(1'b0, 32'd0, 1'b0);
      mctr = 32'd1;
      stream(8, 1'b0);
      check_eq("bp_ready_low", 64'(link.ready), 64'd0);
      check_eq("bp_head", 64'(link.out_data), 64'd1);
      stream(2, 1'b1);
      check_eq("bp_beats", 64'(beat_cnt), 64'd5);
      check_eq("bp_err", 64'(err_cnt), 64'd1);
      stream(20, 1'b1);
      check_eq("bp_err_stable", 64'(err_cnt), 64'd1);
      step(1'b0, 32'd0, 1'b1);
      step(1'b0, 32'd0, 1'b1);

      // Wrap of the sequence through zero.
      pulse_reset();
      step(1'b0, 32'd0, 1'b1);
      mctr = 32'hFFFF_FFFE;
      stream(4, 1'b1);
      check_eq("wrap_err", 64'(err_cnt), 64'd0);
      check_eq("wrap_last", 64'(last_data), 64'd1);
      step(1'b0, 32'd0, 1'b1);

      // Reset with three beats buffered, then re-arm.
      mctr = 32'd50;
      stream(3, 1'b0);
      check_eq("mid_buffered", 64'(link.out_valid), 64'd1);
      pulse_reset();
      check_eq("mid_beats0", 64'(beat_cnt), 64'd0);
      step(1'b0, 32'd0, 1'b1);
      mctr = 32'd100;
      stream(5, 1'b1);
      check_eq("rearm_err", 64'(err_cnt), 64'd0);

      // Random traffic: bursty valid, varying sink readiness, occasional jumps.
      for (int blk = 0; blk < 20; blk++) begin
         int unsigned rdy_pct;
         rdy_pct = $urandom_range(10, 100);
         for (int i = 0; i < 100; i++) begin
            bit v;
            v = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) mctr = $urandom;
            step(v, mctr, ($urandom_range(1, 100) <= rdy_pct));
            if (v) mctr = mctr + 32'd1;
         end
      end

      // Error counter saturation.
      pulse_reset();
      step(1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 70001; i++) step(1'b1, 32'd5, 1'b1);
      check_eq("err_saturated", 64'(err_cnt), 64'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/slave_3.md
Name: slave_3

Overview:
- Downstream consumer for the counting data master on a valid/ready link: accepts 32-bit beats into a small first-word-fall-through FIFO.
- Presents buffered beats on a second valid/ready port toward the sink.
- Checks the stream against an incrementing sequence, counting accepted beats and sequence errors.
- The master does not stall on ready, so gaps caused by backpressure must show up as sequence errors.

Parameters:
- DATA_W, 32, width of data on both ports.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- data  input  DATA_W  beat from upstream master.
- valid  input  1  upstream beat valid.
- ready  output  1  registered; high when the FIFO can accept a beat this cycle.
- out_data  output  DATA_W  head-of-FIFO data.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  sink accepts head this cycle.
- beat_cnt  output  32  accepted upstream beats, wraps modulo 2^32.
- err_cnt  output  ERR_W  sequence mismatches, saturating at all-ones.
- last_data  output  DATA_W  most recently accepted beat.

Behaviour:
- Reset (async assert, sync release on the next clk edge):
  - ready=0, out_valid=0, FIFO count=0, read/write pointers=0.
  - beat_cnt=0, err_cnt=0, last_data=0, seq_armed=0, expected=0.
  - FIFO storage is not cleared.
  - rst asserted mid-transfer drops all buffered beats; no beat accepted in the reset cycle counts.
- Handshakes:
  - push = valid & ready; pop = out_valid & out_ready.
  - A beat transfers only on a rising clk with both signals high.
- ready:
  - Registered: ready <= (count_next < DEPTH), where count_next = count + push - pop.
  - First goes high one clk after reset release.
  - Goes low in the cycle after the FIFO becomes full.
- Full boundary: ready is already low, so no push.
  - A pop while full makes ready high in the next cycle.
- Empty boundary: out_valid=0, so no pop.
  - A push into an empty FIFO sets out_valid=1 in the next cycle, with out_data = that beat (1-cycle latency in to out).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- out_data = mem[rd_ptr] (fall-through); it changes only on pop or on a write into an empty FIFO.
- Sequence checker, on each push:
  - beat_cnt += 1; last_data <= data.
  - If seq_armed=0: set seq_armed=1 and expected <= data+1; no error.
  - Else if data != expected: err_cnt += 1 (saturating) and expected <= data+1 (resync).
  - Else: expected <= expected+1.
  - Arithmetic is modulo 2^DATA_W, so 0xFFFFFFFF followed by 0 is in sequence.
- No state machine beyond the seq_armed flag; no combinational path from valid to ready or from out_ready to ready.

Decomposition:
- Shared package: DATA_W default, a handshake beat typedef (data + valid), and a helper function for the pointer width from DEPTH.
- One natural sub-module: sync_fifo_fwft (storage, pointers, count, registered ready, out_valid).
- The checker and counters stay in slave_3.

Test Plan:
- Reset then continuous beats 1..20 with out_ready=1:
  - ready rises 1 clk after release.
  - out_data follows data with 1-clk latency.
  - beat_cnt=20, err_cnt=0, last_data=20.
- out_ready=0 while master streams from 1, DEPTH=4:
  - ready drops after the 4th accept; FIFO holds 1,2,3,4.
  - After ready returns, the next accepted beat is not 5 → err_cnt=1, expected resyncs.
- out_ready=1 with FIFO full and valid high:
  - Same-cycle pop/push after ready re-asserts keeps count stable at DEPTH-1..DEPTH.
  - Output order is strictly FIFO.
- Sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 → err_cnt=0 (wrap accepted).
- rst pulsed asynchronously mid-stream with 3 beats buffered:
  - out_valid=0, ready=0 and counters=0 immediately.
  - After release, the first beat re-arms the checker with no error.
- Force 70000 mismatches with ERR_W=16 → err_cnt holds at 0xFFFF.
